// File: rtl/semafor_sched.sv
`default_nettype none
// ============================================================================
//  Module      : semafor_sched
//  Description : Phase scheduler for a two-approach traffic light. Latches
//                pedestrian requests, grants them round-robin after a minimum
//                vehicle-green time, inserts an all-red clearance before each
//                walk phase, and handles night-blink and emergency overrides.
//  Revision    : 1.0 - initial release
// ============================================================================
module semafor_sched #(
   parameter int CLR_CYCLES       = 50,
   parameter int WALK_CYCLES      = 200,
   parameter int MIN_GREEN_CYCLES = 500,
   parameter int CNT_W            = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ped_req_a,
   input  logic       ped_req_b,
   input  logic       night_en,
   input  logic       emerg,
   output logic [1:0] sel_out,
   output logic       walk_a,
   output logic       walk_b,
   output logic       pend_a,
   output logic       pend_b,
   output logic [2:0] state_o
);

   localparam logic [2:0] c_st_normal = 3'd0;
   localparam logic [2:0] c_st_clear  = 3'd1;
   localparam logic [2:0] c_st_ped_a  = 3'd2;
   localparam logic [2:0] c_st_ped_b  = 3'd3;
   localparam logic [2:0] c_st_night  = 3'd4;
   localparam logic [2:0] c_st_emerg  = 3'd5;

   localparam logic [CNT_W-1:0] c_clr_last  = CNT_W'(CLR_CYCLES - 1);
   localparam logic [CNT_W-1:0] c_walk_last = CNT_W'(WALK_CYCLES - 1);
   localparam logic [CNT_W-1:0] c_min_green = CNT_W'(MIN_GREEN_CYCLES);
   localparam logic [CNT_W-1:0] c_one       = CNT_W'(1);

   logic [2:0]       r_state, w_state_nx;
   logic [CNT_W-1:0] r_timer, w_timer_nx;
   logic [CNT_W-1:0] r_green, w_green_nx;
   logic             r_ptr, w_ptr_nx;     // round-robin pointer, 0 = A
   logic             r_win, w_win_nx;     // granted side, 0 = A
   logic             r_pend_a, w_pend_a_nx;
   logic             r_pend_b, w_pend_b_nx;
   logic [1:0]       r_sel, w_sel_nx;
   logic             r_walk_a, w_walk_a_nx;
   logic             r_walk_b, w_walk_b_nx;
   logic             w_both;

   assign w_both = r_pend_a & r_pend_b;

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= c_st_normal;
      else       r_state <= w_state_nx;
   end

   // Next-state selection and round-robin grant; emergency always wins
   always_comb begin
      w_state_nx = r_state;
      w_win_nx   = r_win;
      w_ptr_nx   = r_ptr;
      case (r_state)
         c_st_normal: begin
            if (emerg)         w_state_nx = c_st_emerg;
            else if (night_en) w_state_nx = c_st_night;
            else if (r_green == c_min_green && (r_pend_a || r_pend_b)) begin
               w_state_nx = c_st_clear;
               w_win_nx   = w_both ? r_ptr : r_pend_b;
               w_ptr_nx   = w_both ? ~r_ptr : r_ptr;
            end
         end
         c_st_clear: begin
            if (emerg)                     w_state_nx = c_st_emerg;
            else if (r_timer == c_clr_last) w_state_nx = r_win ? c_st_ped_b : c_st_ped_a;
         end
         c_st_ped_a, c_st_ped_b: begin
            // night_en is deliberately ignored here; NORMAL forwards to NIGHT
            if (emerg)                      w_state_nx = c_st_emerg;
            else if (r_timer == c_walk_last) w_state_nx = c_st_normal;
         end
         c_st_night: begin
            if (emerg)          w_state_nx = c_st_emerg;
            else if (!night_en) w_state_nx = c_st_normal;
         end
         c_st_emerg: begin
            if (!emerg) w_state_nx = c_st_normal;
         end
         default: w_state_nx = c_st_normal;
      endcase
   end

   // Timer, green counter and request-latch next values
   always_comb begin
      w_timer_nx = '0;
      if (w_state_nx == r_state && (r_state == c_st_clear ||
          r_state == c_st_ped_a || r_state == c_st_ped_b))
         w_timer_nx = r_timer + c_one;

      // Held at zero outside NORMAL so every entry to NORMAL starts from 0
      w_green_nx = '0;
      if (r_state == c_st_normal)
         w_green_nx = (r_green == c_min_green) ? r_green : r_green + c_one;

      w_pend_a_nx = r_pend_a | ped_req_a;
      if (r_state == c_st_ped_a) w_pend_a_nx = r_pend_a;
      if (w_state_nx == c_st_ped_a && r_state != c_st_ped_a) w_pend_a_nx = 1'b0;
      // An aborted winner is re-queued so it is served after the emergency
      if (w_state_nx == c_st_emerg &&
          (r_state == c_st_ped_a || (r_state == c_st_clear && !r_win)))
         w_pend_a_nx = 1'b1;

      w_pend_b_nx = r_pend_b | ped_req_b;
      if (r_state == c_st_ped_b) w_pend_b_nx = r_pend_b;
      if (w_state_nx == c_st_ped_b && r_state != c_st_ped_b) w_pend_b_nx = 1'b0;
      if (w_state_nx == c_st_emerg &&
          (r_state == c_st_ped_b || (r_state == c_st_clear && r_win)))
         w_pend_b_nx = 1'b1;
   end

   // Datapath registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_timer  <= '0;
         r_green  <= '0;
         r_ptr    <= 1'b0;
         r_win    <= 1'b0;
         r_pend_a <= 1'b0;
         r_pend_b <= 1'b0;
      end else begin
         r_timer  <= w_timer_nx;
         r_green  <= w_green_nx;
         r_ptr    <= w_ptr_nx;
         r_win    <= w_win_nx;
         r_pend_a <= w_pend_a_nx;
         r_pend_b <= w_pend_b_nx;
      end
   end

   // Output decode of the next state, so registered outputs track r_state
   always_comb begin
      w_sel_nx    = 2'b10;
      w_walk_a_nx = (w_state_nx == c_st_ped_a);
      w_walk_b_nx = (w_state_nx == c_st_ped_b);
      if (w_state_nx == c_st_normal)     w_sel_nx = 2'b00;
      else if (w_state_nx == c_st_night) w_sel_nx = 2'b01;
   end

   // Output registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sel    <= 2'b00;
         r_walk_a <= 1'b0;
         r_walk_b <= 1'b0;
      end else begin
         r_sel    <= w_sel_nx;
         r_walk_a <= w_walk_a_nx;
         r_walk_b <= w_walk_b_nx;
      end
   end

   assign sel_out = r_sel;
   assign walk_a  = r_walk_a;
   assign walk_b  = r_walk_b;
   assign pend_a  = r_pend_a;
   assign pend_b  = r_pend_b;
   assign state_o = r_state;

endmodule
`default_nettype wire

// File: tb/tb_semafor_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_semafor_sched
//  Description : Self-checking bench for semafor_sched with short phase
//                parameters; a per-cycle vector table plus directed corner
//                sequences for collisions and asynchronous reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_semafor_sched;

   logic       clk;
   logic       reset;
   logic       ped_req_a, ped_req_b, night_en, emerg;
   logic [1:0] sel_out;
   logic       walk_a, walk_b, pend_a, pend_b;
   logic [2:0] state_o;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [3:0] in;    // {req_a, req_b, night_en, emerg}
      int         n;     // clock edges the row is held; checked after each
      logic [8:0] exp;   // {state, sel, walk_a, walk_b, pend_a, pend_b}
   } vec_t;

   vec_t tbl[$];

   logic mon_en;
   logic walk_seen;

   semafor_sched #(
      .CLR_CYCLES      (4),
      .WALK_CYCLES     (8),
      .MIN_GREEN_CYCLES(16),
      .CNT_W           (16)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .ped_req_a(ped_req_a),
      .ped_req_b(ped_req_b),
      .night_en (night_en),
      .emerg    (emerg),
      .sel_out  (sel_out),
      .walk_a   (walk_a),
      .walk_b   (walk_b),
      .pend_a   (pend_a),
      .pend_b   (pend_b),
      .state_o  (state_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Records any walk phase while the collision window is being watched
   always @(negedge clk) begin
      if (mon_en && (walk_a || walk_b || state_o == 3'd2 || state_o == 3'd3))
         walk_seen = 1'b1;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic add(input logic [3:0] in, input int n, input logic [2:0] st,
                      input logic [1:0] sel, input logic [3:0] wp);
      vec_t v;
      v.in  = in;
      v.n   = n;
      v.exp = {st, sel, wp};
      tbl.push_back(v);
   endtask

   task automatic wait_state(input logic [2:0] tgt, input int max, input string name);
      int k = 0;
      while (state_o !== tgt && k < max) begin
         step();
         k++;
      end
      check(name, {29'd0, state_o}, {29'd0, tgt});
   endtask

   function automatic logic [8:0] outs();
      return {state_o, sel_out, walk_a, walk_b, pend_a, pend_b};
   endfunction

   initial begin
      ped_req_a = 0; ped_req_b = 0; night_en = 0; emerg = 0;
      mon_en = 0; walk_seen = 0;
      reset = 1'b1;

      //  in      n   st  sel  {wa,wb,pa,pb}
      // single request A
      add(4'b0000,  2, 0, 2'b00, 4'b0000);
      add(4'b1000,  1, 0, 2'b00, 4'b0010);
      add(4'b0000, 13, 0, 2'b00, 4'b0010);
      add(4'b0000,  4, 1, 2'b10, 4'b0010);
      add(4'b0000,  8, 2, 2'b10, 4'b1000);
      add(4'b0000,  1, 0, 2'b00, 4'b0000);
      // both pending: pointer at A grants A
      add(4'b1100,  1, 0, 2'b00, 4'b0011);
      add(4'b0000, 15, 0, 2'b00, 4'b0011);
      add(4'b0000,  4, 1, 2'b10, 4'b0011);
      add(4'b0000,  8, 2, 2'b10, 4'b1001);
      add(4'b0000,  1, 0, 2'b00, 4'b0001);
      // both pending again: pointer now at B grants B
      add(4'b1000,  1, 0, 2'b00, 4'b0011);
      add(4'b0000, 15, 0, 2'b00, 4'b0011);
      add(4'b0000,  4, 1, 2'b10, 4'b0011);
      add(4'b0000,  3, 3, 2'b10, 4'b0110);
      // night raised mid-walk: walk completes, one NORMAL cycle, then NIGHT
      add(4'b0010,  5, 3, 2'b10, 4'b0110);
      add(4'b0010,  1, 0, 2'b00, 4'b0010);
      add(4'b0010,  2, 4, 2'b01, 4'b0010);
      add(4'b1010,  1, 4, 2'b01, 4'b0010);
      add(4'b0010,  3, 4, 2'b01, 4'b0010);
      // night off: A served after a full minimum green
      add(4'b0000, 17, 0, 2'b00, 4'b0010);
      add(4'b0000,  4, 1, 2'b10, 4'b0010);
      add(4'b0000,  3, 2, 2'b10, 4'b1000);
      // emergency aborts PED_A, A re-queued
      add(4'b0001,  1, 5, 2'b10, 4'b0010);
      add(4'b0001,  2, 5, 2'b10, 4'b0010);
      add(4'b0000, 17, 0, 2'b00, 4'b0010);
      add(4'b0000,  4, 1, 2'b10, 4'b0010);
      add(4'b0000,  8, 2, 2'b10, 4'b1000);
      add(4'b0000,  1, 0, 2'b00, 4'b0000);

      repeat (2) @(posedge clk);
      #1;
      check("reset_outputs", {23'd0, outs()}, {23'd0, 9'b000_00_0000});
      @(negedge clk);
      reset = 1'b0;

      for (int r = 0; r < tbl.size(); r++) begin
         for (int c = 0; c < tbl[r].n; c++) begin
            {ped_req_a, ped_req_b, night_en, emerg} = tbl[r].in;
            step();
            check($sformatf("row%0d_cyc%0d", r, c), {23'd0, outs()}, {23'd0, tbl[r].exp});
         end
      end
      {ped_req_a, ped_req_b, night_en, emerg} = 4'b0000;

      // Collision: emergency on the same edge the clearance expires
      ped_req_a = 1;
      step();
      ped_req_a = 0;
      check("col_pend_latched", {31'd0, pend_a}, 32'd1);
      wait_state(3'd1, 40, "col_reach_clear");
      mon_en = 1; walk_seen = 0;
      repeat (3) step();
      check("col_still_clear", {29'd0, state_o}, 32'd1);
      emerg = 1;
      step();
      check("col_emerg_state", {29'd0, state_o}, 32'd5);
      check("col_emerg_sel", {30'd0, sel_out}, 32'd2);
      check("col_pend_requeued", {31'd0, pend_a}, 32'd1);
      repeat (2) step();
      emerg = 0;
      step();
      check("col_back_normal", {29'd0, state_o}, 32'd0);
      mon_en = 0;
      check("col_no_walk", {31'd0, walk_seen}, 32'd0);

      // Request on the edge entering PED_A is ignored
      wait_state(3'd1, 40, "pedin_reach_clear");
      repeat (3) step();
      ped_req_a = 1;
      step();
      ped_req_a = 0;
      check("pedin_state", {29'd0, state_o}, 32'd2);
      check("pedin_pend", {31'd0, pend_a}, 32'd0);
      repeat (7) step();
      check("pedin_walk_last", {30'd0, walk_a, pend_a}, 32'd2);
      step();
      check("pedin_after_state", {29'd0, state_o}, 32'd0);
      check("pedin_after_pend", {31'd0, pend_a}, 32'd0);

      // Asynchronous reset in the middle of CLEAR
      ped_req_b = 1;
      step();
      ped_req_b = 0;
      wait_state(3'd1, 40, "arst_reach_clear");
      step();
      check("arst_pre", {23'd0, outs()}, {23'd0, 9'b001_10_0001});
      @(negedge clk);
      #2;
      reset = 1'b1;
      #1;
      check("arst_immediate", {23'd0, outs()}, {23'd0, 9'b000_00_0000});
      @(negedge clk);
      reset = 1'b0;
      repeat (20) step();
      check("arst_request_lost", {23'd0, outs()}, {23'd0, 9'b000_00_0000});

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
